// File: rtl/seq_det_scheduler_pkg.sv
// Shared defaults and helpers for the time-multiplexed pattern detector.
package seq_sched_pkg;

    localparam int             DEF_NCH     = 4;
    localparam int             DEF_PLEN    = 4;
    localparam logic [7:0]     DEF_PATTERN = 8'b0000_1010;

    localparam int             CNT_W       = 16;
    localparam logic [15:0]    CNT_MAX     = 16'hFFFF;

    // Bits needed to hold a count in 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_det_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above i_ptr, wrapping.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] i_req,
    input  logic [CW-1:0]  i_ptr,
    output logic [NCH-1:0] o_gnt,
    output logic [CW-1:0]  o_gnt_idx,
    output logic           o_any
);

    // Two passes: upper slice [ptr..NCH-1] first, then the wrapped slice [0..ptr-1].
    always_comb begin
        logic w_found;
        w_found   = 1'b0;
        o_gnt     = '0;
        o_gnt_idx = '0;
        for (int j = 0; j < NCH; j++) begin
            if (!w_found && i_req[j] && (j >= int'(i_ptr))) begin
                w_found   = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = CW'(j);
            end
        end
        for (int j = 0; j < NCH; j++) begin
            if (!w_found && i_req[j]) begin
                w_found   = 1'b1;
                o_gnt[j]  = 1'b1;
                o_gnt_idx = CW'(j);
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/seq_det_scheduler.sv
// One serial pattern detector shared across NCH channels by a round-robin
// scheduler. Each channel keeps its own match count; one bit is processed
// per cycle. Optional per-channel detection counters: SEQ_DET_COUNT_EN.
module seq_det_scheduler
    import seq_sched_pkg::*;
#(
    parameter int              NCH     = DEF_NCH,
    parameter int              PLEN    = DEF_PLEN,
    parameter logic [PLEN-1:0] PATTERN = PLEN'(DEF_PATTERN),
    parameter int              CW      = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   req_valid,
    input  logic [NCH-1:0]   req_bit,
    output logic [NCH-1:0]   req_ready,
    input  logic [NCH-1:0]   ch_clear,
`ifdef SEQ_DET_COUNT_EN
    input  logic [CW-1:0]    cnt_sel,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_data,
`endif
    output logic             det_valid,
    output logic [CW-1:0]    det_ch
);

    localparam int            MW     = count_width(PLEN);
    localparam logic [MW-1:0] M_LAST = MW'(PLEN - 1);

    logic [MW-1:0]  r_ctx [NCH];
    logic [CW-1:0]  r_ptr;
    logic           r_det_valid;
    logic [CW-1:0]  r_det_ch;

    logic [NCH-1:0] w_gnt;
    logic [CW-1:0]  w_gnt_idx;
    logic           w_any;
    logic [MW-1:0]  w_m;
    logic [MW-1:0]  w_next;
    logic           w_bit;
    logic           w_exp;
    logic           w_full;
    logic           w_take;

    rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
        .i_req     (req_valid),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_any     (w_any)
    );

    // Ready is suppressed while reset is held so no transfer is signalled.
    assign req_ready = reset ? '0 : w_gnt;

    // A clear on the granted channel consumes the bit without advancing it.
    assign w_take    = w_any && !ch_clear[w_gnt_idx];

    // Step the granted channel's context by one bit.
    always_comb begin
        w_m   = r_ctx[w_gnt_idx];
        w_bit = req_bit[w_gnt_idx];
        w_exp = 1'b0;
        for (int j = 0; j < PLEN; j++) begin
            if (w_m == MW'(j)) w_exp = PATTERN[PLEN-1-j];
        end
        w_full = (w_bit == w_exp) && (w_m == M_LAST);
        if (w_bit == w_exp) begin
            w_next = w_full ? '0 : w_m + MW'(1);
        end else begin
            // Mismatch falls back to "first bit seen" only if this bit starts the pattern.
            w_next = (w_bit == PATTERN[PLEN-1]) ? MW'(1) : '0;
        end
    end

    // Context array: clears win over the write-back from the engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) r_ctx[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (ch_clear[k]) begin
                    r_ctx[k] <= '0;
                end else if (w_any && (w_gnt_idx == CW'(k))) begin
                    r_ctx[k] <= w_next;
                end
            end
        end
    end

    // Round-robin pointer moves just past the channel last granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_gnt_idx == CW'(NCH - 1)) ? '0 : w_gnt_idx + CW'(1);
        end
    end

    // Detection pulse with channel tag; the tag holds between pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_det_valid <= 1'b0;
            r_det_ch    <= '0;
        end else if (w_take && w_full) begin
            r_det_valid <= 1'b1;
            r_det_ch    <= w_gnt_idx;
        end else begin
            r_det_valid <= 1'b0;
        end
    end

    assign det_valid = r_det_valid;
    assign det_ch    = r_det_ch;

`ifdef SEQ_DET_COUNT_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    // Saturating per-channel match counters; a clear beats an increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NCH; k++) r_cnt[k] <= '0;
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (cnt_clr && (cnt_sel == CW'(k))) begin
                    r_cnt[k] <= '0;
                end else if (w_take && w_full && (w_gnt_idx == CW'(k)) && (r_cnt[k] != CNT_MAX)) begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Read mux; an out-of-range select reads zero.
    always_comb begin
        cnt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (cnt_sel == CW'(k)) cnt_data = r_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: directed scenarios then random traffic,
// all checked against a per-channel prefix-length reference model.
module tb_seq_det_scheduler;

    localparam int         NCH  = 4;
    localparam int         PLEN = 4;
    localparam logic [3:0] PAT  = 4'b1010;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid, req_bit, ch_clear;
    logic [3:0] req_ready;
    logic       det_valid;
    logic [1:0] det_ch;
`ifdef SEQ_DET_COUNT_EN
    logic [1:0]  cnt_sel;
    logic        cnt_clr;
    logic [15:0] cnt_data;
`endif

    seq_det_scheduler #(.NCH(NCH), .PLEN(PLEN), .PATTERN(PAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_bit   (req_bit),
        .req_ready (req_ready),
        .ch_clear  (ch_clear),
`ifdef SEQ_DET_COUNT_EN
        .cnt_sel   (cnt_sel),
        .cnt_clr   (cnt_clr),
        .cnt_data  (cnt_data),
`endif
        .det_valid (det_valid),
        .det_ch    (det_ch)
    );

    always #5 clk = ~clk;

    // Reference model state: matched prefix length per channel, rr pointer.
    int         mm [NCH];
    int         mcnt [NCH];
    int         mptr;
    logic       exp_dv;
    logic [1:0] exp_dch;
    int         last_k;
    int         det_seen;
    int         n_pass = 0, n_fail = 0, n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            mm[c]   = 0;
            mcnt[c] = 0;
        end
        mptr    = 0;
        exp_dv  = 1'b0;
        exp_dch = 2'd0;
    endtask

    // One clock of stimulus, with grant checked mid-cycle and outputs after the edge.
    task automatic cycle(input logic [3:0] v, input logic [3:0] b, input logic [3:0] c);
        int  k;
        bit  full;
        logic [3:0] egnt;
        @(negedge clk);
        req_valid = v; req_bit = b; ch_clear = c;
        #1;
        k = -1;
        for (int i = 0; i < NCH; i++) begin
            if (k < 0 && v[(mptr + i) % NCH]) k = (mptr + i) % NCH;
        end
        egnt = (k >= 0) ? 4'(1 << k) : 4'd0;
        chk("req_ready", 32'(req_ready), 32'(egnt));
        full = 1'b0;
        if (k >= 0 && !c[k]) begin
            if (b[k] == PAT[PLEN-1-mm[k]]) begin
                if (mm[k] == PLEN - 1) begin
                    full  = 1'b1;
                    mm[k] = 0;
                end else begin
                    mm[k]++;
                end
            end else begin
                mm[k] = (b[k] == PAT[PLEN-1]) ? 1 : 0;
            end
        end
        for (int ch = 0; ch < NCH; ch++) if (c[ch]) mm[ch] = 0;
        if (k >= 0) mptr = (k + 1) % NCH;
        exp_dv = full;
        if (full) exp_dch = k[1:0];
`ifdef SEQ_DET_COUNT_EN
        if (full && mcnt[k] < 65535) mcnt[k]++;
        if (cnt_clr) mcnt[cnt_sel] = 0;
`endif
        last_k = k;
        @(posedge clk);
        #1;
        chk("det_valid", 32'(det_valid), 32'(exp_dv));
        chk("det_ch", 32'(det_ch), 32'(exp_dch));
        if (det_valid === 1'b1) det_seen++;
`ifdef SEQ_DET_COUNT_EN
        chk("cnt_data", 32'(cnt_data), 32'(mcnt[cnt_sel]));
`endif
    endtask

    task automatic send(input int ch, input logic bv, input logic clr);
        cycle(4'(1 << ch), bv ? 4'(1 << ch) : 4'd0, clr ? 4'(1 << ch) : 4'd0);
    endtask

    task automatic send_bits(input int ch, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) send(ch, bits[i], 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        req_valid = '0; req_bit = '0; ch_clear = '0;
        #1;
        model_reset();
        @(posedge clk); #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_det_valid", 32'(det_valid), 32'd0);
        chk("rst_det_ch", 32'(det_ch), 32'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int pos [NCH];
        int ncyc;
        logic [3:0] v, b, c;
        reset = 1'b1;
        req_valid = '0; req_bit = '0; ch_clear = '0;
`ifdef SEQ_DET_COUNT_EN
        cnt_sel = 2'd0; cnt_clr = 1'b0;
`endif
        det_seen = 0;
        model_reset();
        apply_reset();

        // Channel 0 alone: 1010 detects one cycle after the last transfer.
        base = det_seen;
        send_bits(0, 8'b1010, 4);
        cycle(4'd0, 4'd0, 4'd0);
        chk("ch0_single_detect", 32'(det_seen - base), 32'd1);

        // Channel 2: 101010 is non-overlapping (one detect), then 11010 detects.
        base = det_seen;
        send_bits(2, 8'b101010, 6);
        chk("ch2_nonoverlap", 32'(det_seen - base), 32'd1);
        send_bits(2, 8'b11010, 5);
        cycle(4'd0, 4'd0, 4'd0);
        chk("ch2_selfloop", 32'(det_seen - base), 32'd2);

        // All four channels contend, each sending 1010.
        apply_reset();
        base = det_seen;
        for (int ch = 0; ch < NCH; ch++) pos[ch] = 0;
        ncyc = 0;
        for (int t = 0; t < 40; t++) begin
            v = '0; b = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (pos[ch] < PLEN) begin
                    v[ch] = 1'b1;
                    b[ch] = PAT[PLEN-1-pos[ch]];
                end
            end
            if (v == 4'd0) break;
            cycle(v, b, 4'd0);
            ncyc++;
            if (last_k >= 0) pos[last_k]++;
        end
        cycle(4'd0, 4'd0, 4'd0);
        chk("rr_cycles", 32'(ncyc), 32'd16);
        chk("rr_detects", 32'(det_seen - base), 32'd4);

        // Clear on channel 1 with its final bit; channel 3 interleaved still detects.
        base = det_seen;
        send(1, 1'b1, 1'b0); send(3, 1'b1, 1'b0);
        send(1, 1'b0, 1'b0); send(3, 1'b0, 1'b0);
        send(1, 1'b1, 1'b0); send(3, 1'b1, 1'b0);
        send(1, 1'b0, 1'b1);
        chk("clear_no_detect", 32'(det_seen - base), 32'd0);
        send(3, 1'b0, 1'b0);
        chk("ch3_detect", 32'(det_seen - base), 32'd1);
        send_bits(1, 8'b010, 3);
        chk("ch1_cleared_ctx", 32'(det_seen - base), 32'd1);

        // Asynchronous reset mid-stream on channel 0.
        send_bits(0, 8'b101, 3);
        @(negedge clk);
        req_valid = 4'b0001; req_bit = 4'b0000;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        chk("async_rst_det", 32'(det_valid), 32'd0);
        @(negedge clk);
        req_valid = '0;
        reset = 1'b0;
        base = det_seen;
        send(0, 1'b0, 1'b0);
        chk("post_rst_no_detect", 32'(det_seen - base), 32'd0);
        send_bits(0, 8'b1010, 4);
        chk("post_rst_detect", 32'(det_seen - base), 32'd1);

`ifdef SEQ_DET_COUNT_EN
        // Counter: three detects on channel 2, then clear coinciding with a match.
        apply_reset();
        cnt_sel = 2'd2;
        for (int i = 0; i < 3; i++) send_bits(2, 8'b1010, 4);
        chk("cnt_three", 32'(cnt_data), 32'd3);
        send_bits(2, 8'b101, 3);
        cnt_clr = 1'b1;
        send(2, 1'b0, 1'b0);
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(cnt_data), 32'd0);
`endif

        // Random traffic with occasional clears.
        apply_reset();
        for (int t = 0; t < 400; t++) begin
            v = 4'($urandom);
            b = 4'($urandom);
            c = '0;
            for (int ch = 0; ch < NCH; ch++) c[ch] = ($urandom_range(0, 15) == 0);
`ifdef SEQ_DET_COUNT_EN
            cnt_sel = 2'($urandom);
            cnt_clr = ($urandom_range(0, 31) == 0);
`endif
            cycle(v, b, c);
        end
`ifdef SEQ_DET_COUNT_EN
        cnt_clr = 1'b0;
`endif
        cycle(4'd0, 4'd0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
